// File: rtl/sdes_pkg.sv
// Shared S-DES widths, round encoding and the E/P expansion used by the
// keymix stage and later by the key-schedule and Fk assembly.
package sdes_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  localparam logic ROUND_K1 = 1'b0;
  localparam logic ROUND_K2 = 1'b1;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skidState_t;

  // E/P = {n4,n1,n2,n3,n2,n3,n4,n1} with n1 as the nibble MSB
  function automatic logic [BYTE_W-1:0] ep_expand(input logic [NIBBLE_W-1:0] n);
    return {n[0], n[3], n[2], n[1], n[2], n[1], n[0], n[3]};
  endfunction

endpackage

// File: rtl/sdes_skid_buf.sv
// Two-entry valid/ready skid buffer; with SKID_EN=0 it degrades to a single
// output register whose ready looks through to outReady.
//
// state      | meaning
// SKID_EMPTY | nothing held, outValid low
// SKID_ONE   | output register holds the head item
// SKID_FULL  | output register plus skid register both hold items
module sdes_skid_buf
  import sdes_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
);

  skidState_t       state, nextState;
  logic [WIDTH-1:0] skidData;
  logic             push, pop, loadOut, loadSkid, moveSkid;

  assign inReady  = SKID_EN ? (state != SKID_FULL)
                            : ((state == SKID_EMPTY) || outReady);
  assign outValid = (state != SKID_EMPTY);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  always_comb begin
    nextState = state;
    loadOut   = 1'b0;
    loadSkid  = 1'b0;
    moveSkid  = 1'b0;
    case (state)
      SKID_EMPTY: begin
        if (push) begin
          nextState = SKID_ONE;
          loadOut   = 1'b1;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          loadOut = 1'b1;
        end else if (push) begin
          nextState = SKID_FULL;
          loadSkid  = 1'b1;
        end else if (pop) begin
          nextState = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          nextState = SKID_ONE;
          moveSkid  = 1'b1;
        end
      end
      default: nextState = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state    <= SKID_EMPTY;
      outData  <= '0;
      skidData <= '0;
    end else begin
      state <= nextState;
      if (loadOut) begin
        outData <= inData;
      end else if (moveSkid) begin
        outData <= skidData;
      end
      if (loadSkid) begin
        skidData <= inData;
      end
    end
  end

endmodule

// File: rtl/sdes_ep_keymix.sv
// S-DES expand/permute plus subkey mix, registered into a skid buffer that
// feeds the S0/S1 S-box inputs over valid/ready.
module sdes_ep_keymix
  import sdes_pkg::*;
#(
  parameter bit AUTO_ROUND = 1'b1,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                keyLoad,
  input  logic [BYTE_W-1:0]   subKey1,
  input  logic [BYTE_W-1:0]   subKey2,
  input  logic                inValid,
  output logic                inReady,
  input  logic [NIBBLE_W-1:0] rightHalf,
  input  logic                roundIn,
  output logic                outValid,
  input  logic                outReady,
  output logic [NIBBLE_W-1:0] leftSide,
  output logic [NIBBLE_W-1:0] rightSide,
  output logic                roundOut
);

  localparam int PAYLOAD_W = 1 + BYTE_W;

  logic [BYTE_W-1:0]    k1Reg, k2Reg, roundKey, mixed;
  logic                 keysReady, toggle, round, bufReady, accept;
  logic [PAYLOAD_W-1:0] outWord;

  assign inReady  = keysReady && bufReady;
  assign accept   = inValid && inReady;
  assign round    = AUTO_ROUND ? toggle : roundIn;
  assign roundKey = (round == ROUND_K2) ? k2Reg : k1Reg;
  // Mixing at capture means a later keyLoad never disturbs buffered items
  assign mixed    = ep_expand(rightHalf) ^ roundKey;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      k1Reg     <= '0;
      k2Reg     <= '0;
      keysReady <= 1'b0;
      toggle    <= ROUND_K1;
    end else begin
      if (keyLoad) begin
        k1Reg     <= subKey1;
        k2Reg     <= subKey2;
        keysReady <= 1'b1;
        toggle    <= ROUND_K1;
      end else if (accept && AUTO_ROUND) begin
        toggle <= ~toggle;
      end
    end
  end

  sdes_skid_buf #(
    .WIDTH   (PAYLOAD_W),
    .SKID_EN (SKID_EN)
  ) uSkid (
    .clk      (clk),
    .resetN   (resetN),
    .inValid  (inValid && keysReady),
    .inReady  (bufReady),
    .inData   ({round, mixed}),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outWord)
  );

  assign {roundOut, leftSide, rightSide} = outWord;

endmodule

// File: tb/tb_sdes_ep_keymix.sv
// Bench for sdes_ep_keymix: one auto-round/skid instance and one
// roundIn/no-skid instance, both checked against a queue-based model.
module tb_sdes_ep_keymix;

  logic       clk = 1'b0;
  logic       resetN, keyLoad, inValid, roundIn, outReady;
  logic [7:0] subKey1, subKey2;
  logic [3:0] rightHalf;

  logic       inReady0, outValid0, roundOut0;
  logic [3:0] leftSide0, rightSide0;
  logic       inReady1, outValid1, roundOut1;
  logic [3:0] leftSide1, rightSide1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdes_ep_keymix #(.AUTO_ROUND(1'b1), .SKID_EN(1'b1)) dut0 (
    .clk(clk), .resetN(resetN), .keyLoad(keyLoad), .subKey1(subKey1),
    .subKey2(subKey2), .inValid(inValid), .inReady(inReady0),
    .rightHalf(rightHalf), .roundIn(roundIn), .outValid(outValid0),
    .outReady(outReady), .leftSide(leftSide0), .rightSide(rightSide0),
    .roundOut(roundOut0)
  );

  sdes_ep_keymix #(.AUTO_ROUND(1'b0), .SKID_EN(1'b0)) dut1 (
    .clk(clk), .resetN(resetN), .keyLoad(keyLoad), .subKey1(subKey1),
    .subKey2(subKey2), .inValid(inValid), .inReady(inReady1),
    .rightHalf(rightHalf), .roundIn(roundIn), .outValid(outValid1),
    .outReady(outReady), .leftSide(leftSide1), .rightSide(rightSide1),
    .roundOut(roundOut1)
  );

  // reference model state
  localparam int EP_ORDER [8] = '{4, 1, 2, 3, 2, 3, 4, 1};
  logic       mKeysReady;
  logic [7:0] mK1, mK2;
  logic       mToggle;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  function automatic logic [7:0] refEp(input logic [3:0] r);
    logic       nib [1:4];
    logic [7:0] res;
    for (int i = 1; i <= 4; i++) nib[i] = r[4-i];
    for (int k = 0; k < 8; k++) res[7-k] = nib[EP_ORDER[k]];
    return res;
  endfunction

  task automatic checkEq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mKeysReady = 1'b0;
    mK1 = '0;
    mK2 = '0;
    mToggle = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  // Called just after a negedge with inputs set: checks outputs, advances the
  // model across the coming posedge, returns at the following negedge.
  task automatic step();
    logic       rdy0, rdy1, acc0, acc1, rnd;
    logic [7:0] key;
    #1;
    rdy0 = mKeysReady && (q0.size() < 2);
    rdy1 = mKeysReady && (q1.size() == 0 || outReady);
    checkEq("inReady0", 9'(inReady0), 9'(rdy0));
    checkEq("inReady1", 9'(inReady1), 9'(rdy1));
    checkEq("outValid0", 9'(outValid0), 9'(q0.size() != 0));
    checkEq("outValid1", 9'(outValid1), 9'(q1.size() != 0));
    if (q0.size() != 0) checkEq("data0", {roundOut0, leftSide0, rightSide0}, q0[0]);
    if (q1.size() != 0) checkEq("data1", {roundOut1, leftSide1, rightSide1}, q1[0]);
    if (!resetN) begin
      modelReset();
    end else begin
      acc0 = inValid && rdy0;
      acc1 = inValid && rdy1;
      if (q0.size() != 0 && outReady) void'(q0.pop_front());
      if (q1.size() != 0 && outReady) void'(q1.pop_front());
      if (acc0) begin
        rnd = mToggle;
        key = rnd ? mK2 : mK1;
        q0.push_back({rnd, refEp(rightHalf) ^ key});
      end
      if (acc1) begin
        rnd = roundIn;
        key = rnd ? mK2 : mK1;
        q1.push_back({rnd, refEp(rightHalf) ^ key});
      end
      if (keyLoad) begin
        mK1 = subKey1;
        mK2 = subKey2;
        mKeysReady = 1'b1;
        mToggle = 1'b0;
      end else if (acc0) begin
        mToggle = ~mToggle;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic loadKeys(input logic [7:0] a, input logic [7:0] b);
    keyLoad = 1'b1; subKey1 = a; subKey2 = b;
    step();
    keyLoad = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; keyLoad = 1'b0; inValid = 1'b0; roundIn = 1'b0;
    outReady = 1'b1; subKey1 = '0; subKey2 = '0; rightHalf = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("rstData0", {roundOut0, leftSide0, rightSide0}, 9'h0);
    checkEq("rstData1", {roundOut1, leftSide1, rightSide1}, 9'h0);
    resetN = 1'b1;

    // no keys yet: nothing accepted
    inValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rightHalf = 4'($urandom);
      step();
    end
    inValid = 1'b0;

    // first K1 item
    loadKeys(8'b1010_0100, 8'h00);
    inValid = 1'b1; rightHalf = 4'b1010; roundIn = 1'b0;
    step();
    inValid = 1'b0;
    checkEq("t2_item0", {roundOut0, leftSide0, rightSide0}, 9'b0_1111_0001);
    checkEq("t2_item1", {roundOut1, leftSide1, rightSide1}, 9'b0_1111_0001);
    step();

    // auto round alternation
    loadKeys(8'h0F, 8'hF0);
    inValid = 1'b1; rightHalf = 4'b1111; roundIn = 1'b0;
    step();
    checkEq("t3_first0", {roundOut0, leftSide0, rightSide0}, 9'b0_1111_0000);
    checkEq("t3_first1", {roundOut1, leftSide1, rightSide1}, 9'b0_1111_0000);
    roundIn = 1'b1;
    step();
    inValid = 1'b0;
    checkEq("t3_second0", {roundOut0, leftSide0, rightSide0}, 9'b1_0000_1111);
    checkEq("t3_second1", {roundOut1, leftSide1, rightSide1}, 9'b1_0000_1111);
    step();

    // backpressure: skid fills, order preserved on release
    outReady = 1'b0; inValid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      rightHalf = 4'(i); roundIn = 1'(i);
      if (i == 3) checkEq("t4_full", 9'(inReady0), 9'h0);
      step();
    end
    inValid = 1'b0; outReady = 1'b1;
    repeat (3) step();

    // keyLoad on the same edge as an accept uses the old K1
    loadKeys(8'h00, 8'h5A);
    keyLoad = 1'b1; subKey1 = 8'hFF; subKey2 = 8'h5A;
    inValid = 1'b1; rightHalf = 4'b0000; roundIn = 1'b0;
    step();
    keyLoad = 1'b0;
    checkEq("t5_oldKey0", {roundOut0, leftSide0, rightSide0}, 9'b0_0000_0000);
    checkEq("t5_oldKey1", {roundOut1, leftSide1, rightSide1}, 9'b0_0000_0000);
    step();
    inValid = 1'b0;
    checkEq("t5_newKey0", {roundOut0, leftSide0, rightSide0}, 9'b0_1111_1111);
    checkEq("t5_newKey1", {roundOut1, leftSide1, rightSide1}, 9'b0_1111_1111);
    step();

    // reset with items buffered drops items and keys
    outReady = 1'b0; inValid = 1'b1;
    rightHalf = 4'h6; step();
    rightHalf = 4'h9; step();
    resetN = 1'b0; step();
    resetN = 1'b1;
    checkEq("t6_valid0", 9'(outValid0), 9'h0);
    checkEq("t6_ready0", 9'(inReady0), 9'h0);
    checkEq("t6_ready1", 9'(inReady1), 9'h0);
    outReady = 1'b1;
    repeat (4) step();
    inValid = 1'b0;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      resetN    = ($urandom_range(0, 149) != 0);
      keyLoad   = ($urandom_range(0, 11) == 0);
      subKey1   = 8'($urandom);
      subKey2   = 8'($urandom);
      inValid   = ($urandom_range(0, 3) != 0);
      outReady  = 1'($urandom);
      rightHalf = 4'($urandom);
      roundIn   = 1'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdes_ep_keymix.md
Name: sdes_ep_keymix

Overview:
Registered S-DES expand/permute and subkey-mix stage. It sits directly upstream of the S-box pair: S0 takes leftSide and S1 takes rightSide.
- Takes the 4-bit right half of the round state.
- Applies E/P (4→8 bits) and XORs the result with the round subkey K1 or K2.
- Presents the two 4-bit S-box inputs over a valid/ready handshake.
- Holds both subkeys internally and buffers with a 2-entry skid for full throughput under backpressure.

Parameters:
AUTO_ROUND, 1, 1 = subkey alternates K1,K2,K1,... per accepted item; 0 = subkey selected by roundIn.
SKID_EN, 1, 1 = 2-entry skid buffer (inReady registered); 0 = single output register, inReady = !outValid || outReady.

Ports:
clk  input  1  clock; all logic on rising edge.
resetN  input  1  synchronous active-low reset.
keyLoad  input  1  one-cycle strobe; latches subKey1/subKey2.
subKey1  input  8  round-1 subkey K1.
subKey2  input  8  round-2 subkey K2.
inValid  input  1  upstream data valid.
inReady  output  1  stage can accept.
rightHalf  input  4  R nibble, bit3 = n1 (MSB-first numbering).
roundIn  input  1  0 = K1, 1 = K2; used only when AUTO_ROUND=0.
outValid  output  1  S-box inputs valid.
outReady  input  1  downstream accepts.
leftSide  output  4  E/P^K bits[7:4] → S0.
rightSide  output  4  E/P^K bits[3:0] → S1.
roundOut  output  1  subkey used for this item (0 = K1, 1 = K2).

Behaviour:
- Clock and reset: single clock clk; reset resetN is synchronous, active-low.
- Reset values:
  - outValid=0, leftSide=0, rightSide=0, roundOut=0, inReady=0.
  - keysReady=0, skid empty, round toggle=0 (next = K1).
- Key loading:
  - keyLoad=1 on an edge → K1/K2 registers updated; keysReady=1 from the next cycle.
  - The round toggle clears to K1 on keyLoad.
  - keyLoad is allowed at any time. Items already accepted keep their computed value, because the mix happens at capture.
  - keyLoad and an accept on the same edge → the accepted item uses the OLD keys, and the toggle ends at K1.
- inReady:
  - Is 0 while keysReady=0.
  - SKID_EN=1: inReady = keysReady && !skidFull (registered).
  - SKID_EN=0: inReady = keysReady && (!outValid || outReady).
- Accept occurs when inValid && inReady.
- E/P: {n4,n1,n2,n3,n2,n3,n4,n1}, MSB first, where n1..n4 = rightHalf[3:0].
- Mix: mixed = EP ^ K. K = K2 if the selected round is 1, else K1.
- Round select:
  - AUTO_ROUND=1: round = toggle; the toggle flips on every accept.
  - AUTO_ROUND=0: round = roundIn, sampled at accept.
- Latency: 1 cycle from accept to outValid when the output register is empty. Throughput is 1 item/cycle with outReady held high.
- Skid (SKID_EN=1):
  - An accept while the output register holds an item and outReady=0 → the item goes to the skid, and inReady drops the next cycle.
  - When the output drains, the skid moves to the output on the same edge.
  - Order is strictly FIFO.
  - The upstream never loses a beat.
- outValid stays high and the outputs stay stable until outReady=1 (AXI-style; no combinational valid-ready dependency on the out side).
- Reset mid-operation discards all buffered items and keys; everything returns to the reset values above.
- inValid=1 with keysReady=0: nothing is accepted and no state changes.

Decomposition:
- Shared package sdes_pkg:
  - widths NIBBLE_W=4, BYTE_W=8;
  - round encoding ROUND_K1=0, ROUND_K2=1;
  - function ep_expand(4b)→8b, reused later by the key-schedule and Fk assembly.
- One natural sub-module: sdes_skid_buf (WIDTH param, 2-entry valid/ready skid). Payload = {roundOut, leftSide, rightSide} = 9 bits.
- E/P and XOR stay inline in sdes_ep_keymix.

Test Plan:
1. Reset, then inValid=1 with no keyLoad → inReady=0, outValid=0 for 10 cycles.
2. keyLoad K1=8'b10100100, K2=8'h00; accept rightHalf=4'b1010, outReady=1 → next cycle outValid=1, leftSide=4'b1111, rightSide=4'b0001, roundOut=0.
3. AUTO_ROUND=1: accept rightHalf=4'b1111 twice with K1=8'h0F, K2=8'hF0 → outputs {1111,0000,r0} then {0000,1111,r1}.
4. outReady=0, stream 3 items → 2 accepted, inReady=0 on the third. Release outReady → items emerge in order, none lost or duplicated.
5. keyLoad (K1 8'h00→8'hFF) on the same edge as the accept of rightHalf=4'b0000 → that item gives 0000/0000; the next K1 item gives 1111/1111.
6. Drop resetN for 1 cycle with 2 items buffered → outValid=0, inReady=0; keys must be reloaded before any accept.
